// File: rtl/prbs23_tx_src.sv
// rtl/prbs23_tx_src.sv - PRBS23 framed byte source with gap and error injection
//
// Purpose: generates a continuous PRBS23 (x^23+x^18+1) byte stream, cut into
// frames of frame_len bytes separated by gap_len idle cycles, on an AXI-Stream
// byte master. A single inj_err pulse flips bit 0 of one later byte.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en                    run enable; dropping it ends after the current frame
//   frame_len, gap_len    bytes per frame (0 acts as 1), idle cycles between frames
//   inj_err               request a single-bit error on a following byte
//   m_axis_tdata/tvalid/tready/tlast   byte stream master
//   busy                  machine is not idle
//   n_frames, n_inj       saturating counts of sent frames and injected errors

module prbs23_tx_src #(
    parameter logic [22:0] pSEED      = 23'h7FFFFF,
    parameter int          pMSB_FIRST = 0,
    parameter int          pCNT_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [15:0]       frame_len,
    input  logic [15:0]       gap_len,
    input  logic              inj_err,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [pCNT_W-1:0] n_frames,
    output logic [pCNT_W-1:0] n_inj
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t      state, state_n;
    logic [22:0] lfsr, lfsr_n, step_src, step_state;
    logic [7:0]  step_byte, data_r, data_n;
    logic        valid_r, valid_n, last_r, last_n;
    logic        pend, pend_n, cur_inj, cur_inj_n;
    logic [15:0] cnt, cnt_n, gap_cnt, gap_n, flen;
    logic        hs, inj_done, frame_done, load;

    // Eight Fibonacci steps; returns {new state, byte}. The first generated bit
    // lands in tdata[0] (LSB-first) or tdata[7] (MSB-first).
    function automatic logic [30:0] prbs_step8(input logic [22:0] s);
        logic [22:0] t;
        logic [7:0]  d;
        logic        b;
        t = s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = t[22] ^ t[17];
            t = {t[21:0], b};
            if (pMSB_FIRST != 0) d = {d[6:0], b};
            else                 d = {b, d[7:1]};
        end
        return {t, d};
    endfunction

    // Starting from IDLE always restarts the sequence from the seed.
    assign step_src = (state == S_IDLE) ? pSEED : lfsr;
    assign {step_state, step_byte} = prbs_step8(step_src);

    assign hs         = valid_r & m_axis_tready;
    assign inj_done   = hs & cur_inj;
    assign frame_done = hs & last_r;
    assign flen       = (frame_len == 16'd0) ? 16'd1 : frame_len;
    // A pulse arriving on the cycle the corrupted byte is accepted is dropped,
    // like any other pulse that lands while a request is already pending.
    assign pend_n     = inj_done ? 1'b0 : (pend | inj_err);

    always_comb begin
        state_n   = state;
        lfsr_n    = lfsr;
        data_n    = data_r;
        valid_n   = valid_r;
        last_n    = last_r;
        cnt_n     = cnt;
        gap_n     = gap_cnt;
        cur_inj_n = cur_inj;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    load    = 1'b1;
                    cnt_n   = flen;
                    last_n  = (flen == 16'd1);
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (last_r) begin
                        if (!en) begin
                            state_n   = S_IDLE;
                            valid_n   = 1'b0;
                            last_n    = 1'b0;
                            cur_inj_n = 1'b0;
                        end else if (gap_len == 16'd0) begin
                            load   = 1'b1;
                            cnt_n  = flen;
                            last_n = (flen == 16'd1);
                        end else begin
                            state_n   = S_GAP;
                            gap_n     = gap_len;
                            valid_n   = 1'b0;
                            last_n    = 1'b0;
                            cur_inj_n = 1'b0;
                        end
                    end else begin
                        load   = 1'b1;
                        cnt_n  = cnt - 16'd1;
                        last_n = (cnt == 16'd2);
                    end
                end
            end
            S_GAP: begin
                // Leaving on the count of 1 gives exactly gap_len idle cycles.
                if (gap_cnt <= 16'd1) begin
                    if (en) begin
                        load    = 1'b1;
                        cnt_n   = flen;
                        last_n  = (flen == 16'd1);
                        state_n = S_SEND;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // The error is baked into the registered byte so it holds through stalls.
        if (load) begin
            lfsr_n    = step_state;
            data_n    = step_byte ^ {7'b0, pend_n};
            cur_inj_n = pend_n;
            valid_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lfsr     <= pSEED;
            data_r   <= 8'h00;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            cnt      <= 16'd0;
            gap_cnt  <= 16'd0;
            pend     <= 1'b0;
            cur_inj  <= 1'b0;
            n_frames <= '0;
            n_inj    <= '0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            data_r   <= data_n;
            valid_r  <= valid_n;
            last_r   <= last_n;
            cnt      <= cnt_n;
            gap_cnt  <= gap_n;
            pend     <= pend_n;
            cur_inj  <= cur_inj_n;
            if (frame_done && n_frames != {pCNT_W{1'b1}}) n_frames <= n_frames + 1'b1;
            if (inj_done && n_inj != {pCNT_W{1'b1}})      n_inj    <= n_inj + 1'b1;
        end
    end

    assign m_axis_tdata  = data_r;
    assign m_axis_tvalid = valid_r;
    assign m_axis_tlast  = last_r;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_prbs23_tx_src.sv
// tb/tb_prbs23_tx_src.sv - scoreboard bench for prbs23_tx_src
module tb_prbs23_tx_src;

    logic        clk = 1'b0;
    logic        rst, en, inj_err, tready;
    logic [15:0] frame_len, gap_len;
    logic [7:0]  tdata;
    logic        tvalid, tlast, busy;
    logic [23:0] n_frames, n_inj;

    prbs23_tx_src dut (
        .clk(clk), .rst(rst), .en(en), .frame_len(frame_len), .gap_len(gap_len),
        .inj_err(inj_err), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy),
        .n_frames(n_frames), .n_inj(n_inj)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          gap_cycles = 0;
    int          exp_frames = 0;
    logic        rand_rdy = 1'b0;
    logic [8:0]  exp_q[$];
    logic [7:0]  cap[$];
    logic [22:0] m_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference generator, bit-serial, LSB-first.
    task automatic model_byte(output logic [7:0] d);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = m_s[22] ^ m_s[17];
            m_s = {m_s[21:0], b};
            d[i] = b;
        end
    endtask

    task automatic push_frames(input int nf, input int fl);
        logic [7:0] d;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < fl; i++) begin
                model_byte(d);
                exp_q.push_back({(i == fl - 1), d});
            end
            exp_frames++;
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (hs_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_hs timeout actual=%0d required=%0d", hs_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("idle_busy", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("n_frames", n_frames, exp_frames);
    endtask

    task automatic monitor();
        logic       prev_stall = 1'b0;
        logic [8:0] prev = '0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("stall_stable", {tvalid, tlast, tdata}, {1'b1, prev});
                if (tvalid && tready) begin
                    cap.push_back(tdata);
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {tlast, tdata}, 9'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream", {tlast, tdata}, e);
                    end
                end
                if (busy && !tvalid) gap_cycles++;
                prev_stall = tvalid && !tready;
                prev = {tlast, tdata};
            end
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) tready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int g0, b0;
        rst = 1'b1; en = 1'b0; inj_err = 1'b0; tready = 1'b1;
        frame_len = 16'd4; gap_len = 16'd0;
        fork
            monitor();
            rdy_driver();
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_n_frames", n_frames, 0);
        chk("rst_n_inj", n_inj, 0);
        rst = 1'b0;
        tick();

        // Back-to-back 4-byte frames
        m_s = 23'h7FFFFF; cap.delete(); g0 = gap_cycles; b0 = hs_cnt;
        push_frames(3, 4);
        en = 1'b1;
        wait_hs(b0 + 9, 200);
        en = 1'b0;
        wait_idle(200);
        chk("first_byte0", cap[0], 8'h00);
        chk("first_byte1", cap[1], 8'h00);
        chk("first_byte2", cap[2], 8'h7C);
        chk("no_bubble", gap_cycles - g0, 0);

        // 3-byte frames, 5-cycle gap, stream continues across the gap
        m_s = 23'h7FFFFF; g0 = gap_cycles; b0 = hs_cnt;
        push_frames(2, 3);
        frame_len = 16'd3; gap_len = 16'd5; en = 1'b1;
        tick();
        @(negedge clk);
        chk("en_latency_tvalid", tvalid, 1);
        wait_hs(b0 + 4, 200);
        en = 1'b0;
        wait_idle(200);
        chk("gap_cycles", gap_cycles - g0, 5);

        // Random stalls over 1001 bytes
        m_s = 23'h7FFFFF; g0 = gap_cycles; b0 = hs_cnt;
        push_frames(143, 7);
        frame_len = 16'd7; gap_len = 16'd2; rand_rdy = 1'b1; en = 1'b1;
        wait_hs(b0 + 995, 20000);
        en = 1'b0;
        wait_idle(5000);
        rand_rdy = 1'b0; tready = 1'b1;
        chk("rand_gap_cycles", gap_cycles - g0, 284);

        // en dropped at byte 2 of an 8-byte frame
        m_s = 23'h7FFFFF; b0 = hs_cnt;
        push_frames(1, 8);
        frame_len = 16'd8; gap_len = 16'd3; en = 1'b1;
        wait_hs(b0 + 2, 200);
        en = 1'b0;
        wait_idle(200);
        chk("stop_tvalid", tvalid, 0);

        // Re-enable (seed reload) with error injection and a second ignored pulse
        m_s = 23'h7FFFFF; cap.delete();
        push_frames(1, 8);
        exp_q[exp_q.size() - 7] = exp_q[exp_q.size() - 7] ^ 9'h001;
        frame_len = 16'd8; gap_len = 16'd0; tready = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        inj_err = 1'b1; tick(); inj_err = 1'b0; tick();
        inj_err = 1'b1; tick(); inj_err = 1'b0; tick();
        tready = 1'b1; tick();
        tready = 1'b0; tick(); tick(); tick();
        tready = 1'b1;
        wait_idle(200);
        chk("inj_count", n_inj, 1);
        chk("restart_byte0", cap[0], 8'h00);
        chk("inj_byte1", cap[1], 8'h01);

        // Reset mid-frame while stalled
        frame_len = 16'd5; tready = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_tvalid", tvalid, 1);
        rst = 1'b1; en = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_n_frames", n_frames, 0);
        chk("mid_rst_n_inj", n_inj, 0);
        tick();
        rst = 1'b0; exp_frames = 0;
        tick();

        // frame_len = 0 acts as 1: tlast on every byte
        m_s = 23'h7FFFFF;
        push_frames(4, 1);
        frame_len = 16'd0; gap_len = 16'd0; tready = 1'b1; en = 1'b1;
        tick(); tick(); tick(); tick();
        en = 1'b0;
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs23_tx_src.md
Name: prbs23_tx_src

Overview:
- Transmit-side test traffic source, the counterpart of the receive chain's PRBS23 checker and error counter.
- Generates a PRBS23 byte stream cut into frames of programmable length, with programmable inter-frame gap and single-bit error injection.
- Output is an AXI-Stream byte master feeding the TX FEC/CRC encoder, so the far-end prbs23_check/count_err pair can measure BER.

Parameters:
- pSEED, 23'h7FFFFF: LFSR load value at reset and on each start from IDLE; a zero value is illegal.
- pMSB_FIRST, 0: 1 = first generated bit goes to tdata[7]; 0 = first bit goes to tdata[0]. Must match the checker setting.
- pCNT_W, 24: width of the status counters.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- en  in  1  level; 1 = run, 0 = stop at the end of the current frame
- frame_len  in  16  bytes per frame; 0 is treated as 1
- gap_len  in  16  idle cycles between tlast acceptance and the next frame's first byte
- inj_err  in  1  pulse; flips bit 0 of the next byte accepted in SEND
- m_axis_tdata  out  8  PRBS byte
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of frame
- busy  out  1  state != IDLE
- n_frames  out  pCNT_W  frames sent (tlast accepted)
- n_inj  out  pCNT_W  errors actually injected

Behaviour:
- Reset (rst=1 on a clk edge), required values:
  - state=IDLE; tvalid=0, tlast=0, tdata=0, busy=0.
  - LFSR=pSEED; n_frames=0, n_inj=0; pending-inject flag cleared.
  - Reset mid-frame drops the frame immediately; no tlast is issued.
- LFSR definition: polynomial x^23+x^18+1, Fibonacci form, state s[22:0].
  - One bit step: b=s[22]^s[17]; s<={s[21:0],b}; output b.
  - Eight steps per byte, computed combinationally (unrolled).
  - Bits k..k+7 form one byte; bit k goes to tdata[0] when pMSB_FIRST=0.
- LFSR and byte advance rules:
  - Advance only on a handshake (tvalid&tready).
  - No advance during GAP or IDLE, and no advance while stalled, so the stream is continuous across frames.
- Data register: tdata holds the current byte and stays stable while tvalid=1 and tready=0.
- State machine:
  - IDLE: tvalid=0. If en=1, reload LFSR=pSEED, load the byte counter with max(frame_len,1), present byte 0 with tvalid=1 on the next cycle, go to SEND. Latency from en rising to tvalid=1 is 1 cycle.
  - SEND: tvalid=1; tlast=1 when the remaining count is 1.
    - Each handshake: decrement the count and load the next byte.
    - On a handshake with tlast=1: n_frames+=1. If gap_len=0 and en=1, load the next frame immediately with no bubble (tvalid stays 1). If gap_len>0, go to GAP with gap counter=gap_len. If en=0, go to IDLE.
  - GAP: tvalid=0; decrement once per cycle. At 0, if en=1, go to SEND with count=max(frame_len,1) and no LFSR reload; otherwise go to IDLE.
- frame_len and gap_len are sampled only at frame/gap start; changes mid-frame take effect at the next frame.
- en=0 in mid-frame: the frame completes normally, including tlast.
- Error injection:
  - inj_err sets a pending flag; extra pulses while pending are ignored (not queued).
  - While pending, the byte presented in SEND has bit 0 inverted, and that same modified byte stays stable through any stall.
  - On that byte's handshake: clear the flag, n_inj+=1.
  - The LFSR sequence itself is never altered.
- Counters saturate at all-ones.

Test Plan:
- Reset, en=1, frame_len=4, gap_len=0, tready=1 → first bytes 0x00, 0x00, 0x7C; tlast on the 4th byte; back-to-back frames with no bubble; n_frames increments every 4 handshakes.
- frame_len=3, gap_len=5 → exactly 5 tvalid=0 cycles between tlast acceptance and the next tvalid; LFSR continues (byte 3 of the stream continues the sequence, no restart).
- Random tready stalls over 1000 bytes → tdata/tlast stable during stalls; the byte stream matches the reference LFSR model with no drops or duplicates.
- inj_err pulse during frame → exactly one byte differs from the model, only in bit 0; n_inj=1. A second pulse during the same pending window gives n_inj still 1.
- en dropped at byte 2 of an 8-byte frame → bytes 3..8 still sent with tlast on byte 8; then IDLE, busy=0. Re-enabling restarts from byte 0x00 (seed reload).
- rst asserted mid-frame with tready=0 → next cycle tvalid=0 and counters 0; frame_len=0 gives tlast on every byte.
